// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file sequencer.
// Contents: opcode encodings, opcode field width and the FSM state encoding.
package regseq_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB  = 2'b01;
  localparam logic [OP_W-1:0] OP_ADDI = 2'b10;
  localparam logic [OP_W-1:0] OP_OUT  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWsetup,
    StWpulse,
    StWhold,
    StDone
  } state_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Bus bundle between the sequencer and its environment.
// Groups the instruction handshake, the register-file read/write ports, the result handshake
// and the sticky write-back error flag.
//   master : the sequencer side (drives addresses, strobes and results)
//   slave  : the environment side (instruction source, register file, result consumer)
interface regfile_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
);
  localparam int unsigned INSTR_W = 2 + 3 * ADDR_W;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  Read_Register1;
  logic [ADDR_W-1:0]  Read_Register2;
  logic [DATA_W-1:0]  Read_Data1;
  logic [DATA_W-1:0]  Read_Data2;
  logic [ADDR_W-1:0]  Write_Register;
  logic [DATA_W-1:0]  Write_Data_in;
  logic               RegWrite;
  logic [DATA_W-1:0]  Write_Data_out;
  logic               result_valid;
  logic               result_ready;
  logic [DATA_W-1:0]  result_data;
  logic               result_zero;
  logic               wb_err;

  modport master (
    input  instr_valid, instr, Read_Data1, Read_Data2, Write_Data_out, result_ready,
    output instr_ready, Read_Register1, Read_Register2, Write_Register, Write_Data_in,
           RegWrite, result_valid, result_data, result_zero, wb_err
  );

  modport slave (
    output instr_valid, instr, Read_Data1, Read_Data2, Write_Data_out, result_ready,
    input  instr_ready, Read_Register1, Read_Register2, Write_Register, Write_Data_in,
           RegWrite, result_valid, result_data, result_zero, wb_err
  );

endinterface

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer.
//   op  : opcode (ADD, SUB, ADDI, OUT)
//   a   : rs operand
//   b   : rt operand
//   imm : signed immediate for ADDI
//   y   : result, modulo 2^DATA_W; OUT passes a through
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ADDR_W-1:0] imm,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] imm_sext;
  assign imm_sext = {{(DATA_W - ADDR_W){imm[ADDR_W-1]}}, imm};

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_ADDI: y = a + imm_sext;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle controller driving a register file from the initiator side.
// Accepts one instruction per handshake, reads rs/rt, executes ADD/SUB/ADDI/OUT, writes back
// with a setup/pulse/hold RegWrite sequence and returns the result on a valid/ready port.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : instruction, register-file and result signals (master side)
module regfile_sequencer
  import regseq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input logic                 clk,
  input logic                 reset,
  regfile_sequencer_if.master bus
);

  localparam int unsigned INSTR_W = 2 + 3 * ADDR_W;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               wb_err_q, wb_err_d;

  logic [OP_W-1:0]    op;
  logic [ADDR_W-1:0]  rs, rt, rd;
  logic [DATA_W-1:0]  alu_y;

  assign op = instr_q[INSTR_W-1 -: OP_W];
  assign rs = instr_q[3*ADDR_W-1 -: ADDR_W];
  assign rt = instr_q[2*ADDR_W-1 -: ADDR_W];
  assign rd = instr_q[ADDR_W-1:0];

  regseq_alu #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_alu (
    .op  (op),
    .a   (bus.Read_Data1),
    .b   (bus.Read_Data2),
    .imm (rd),
    .y   (alu_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      instr_q  <= '0;
      res_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      res_q    <= res_d;
      wb_err_q <= wb_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    res_d    = res_q;
    wb_err_d = wb_err_q;
    case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = StRead;
        end
      end
      StRead:   state_d = StExec;
      StExec: begin
        // Operands are captured here, so rd aliasing rs/rt is harmless.
        res_d   = alu_y;
        state_d = (op == OP_OUT) ? StDone : StWsetup;
      end
      StWsetup: state_d = StWpulse;
      StWpulse: state_d = StWhold;
      StWhold: begin
        if (bus.Write_Data_out != res_q) wb_err_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (bus.result_ready) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  logic in_op, in_write, in_done;
  assign in_op    = (state_q != StIdle);
  assign in_write = (state_q == StWsetup) || (state_q == StWpulse) || (state_q == StWhold);
  assign in_done  = (state_q == StDone);

  // All strobes decode straight from state_q so an async reset drops them immediately.
  assign bus.instr_ready    = (state_q == StIdle);
  assign bus.Read_Register1 = in_op ? rs : '0;
  assign bus.Read_Register2 = in_op ? rt : '0;
  assign bus.Write_Register = in_write ? ((op == OP_ADDI) ? rt : rd) : '0;
  assign bus.Write_Data_in  = in_write ? res_q : '0;
  assign bus.RegWrite       = (state_q == StWpulse);
  assign bus.result_valid   = in_done;
  assign bus.result_data    = in_done ? res_q : '0;
  assign bus.result_zero    = in_done && (res_q == '0);
  assign bus.wb_err         = wb_err_q;

endmodule
